regfile_scan_sequencer: RTL and testbench
=========================================

# regfile_scan_sequencer

Sequences one bit-serial register-file operation at a time. It drives the register file's port-1 (destination) and port-2 (source) indices and scan enables, and the shared bit_index. It routes ALU result bits back in as scan_in and recirculates source bits as scan_in2. It sits between instruction decode (command handshake) and the register file top / serial ALU pair, and handles 8-bit and 16-bit (register-pair) operations.

## Interface
- LOG2_NR, 4, register index width (16 indices; 8..15 are special registers)
- REG_BITS, 8, bits per register
- NSHIFT, 2, bits moved per scan cycle
- Derived: CYC = REG_BITS/NSHIFT (4); BI_W = clog2(2*CYC) (3)

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-high; forces the reset state immediately
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high iff state IDLE
- cmd_dst  in  LOG2_NR  destination / port-1 register (16-bit: pair base, bit0 ignored)
- cmd_src  in  LOG2_NR  source / port-2 register (16-bit: pair base, bit0 ignored)
- cmd_wide  in  1  1 = 16-bit operation
- cmd_we  in  1  1 = write ALU result to dst; 0 = dst recirculated unchanged
- stall  in  1  freeze scanning
- reg_index, reg_index2  out  LOG2_NR  register file port indices
- do_scan, do_scan2  out  1  register file scan enables
- bit_index  out  BI_W  current scan step
- rf_scan_out, rf_scan_out2  in  NSHIFT  register file outputs
- alu_result  in  NSHIFT  serial ALU result bits
- scan_in, scan_in2  out  NSHIFT  register file inputs
- op_a, op_b  out  NSHIFT  ALU operands (= rf_scan_out, rf_scan_out2)
- first, last  out  1  first / last scan step of the operation (for carry init / flag capture)
- done  out  1  one-cycle pulse after the final scan step
- err  out  1  valid with done; illegal special-register pairing detected

## Operation
- States: IDLE, SCAN.
- IDLE -> SCAN on cmd_valid && cmd_ready. The command is latched; bit_index is cleared to 0.
- SCAN: each non-stalled cycle, do_scan = 1 and bit_index increments.
- The final step is bit_index == CYC-1 (narrow) or 2*CYC-1 (wide). The cycle after the final step:
  - state returns to IDLE
  - done = 1
  - bit_index returns to 0
- Wide indexing: reg_index = {dst[LOG2_NR-1:1], bit_index[BI_W-1]} and reg_index2 = {src[LOG2_NR-1:1], bit_index[BI_W-1]}. This means low register first, then high register.
- Narrow indexing: bit_index[BI_W-1] stays 0 and the indices are dst/src as latched.
- scan_in = cmd_we ? alu_result : rf_scan_out.
- scan_in2 = rf_scan_out2, so the source is restored.
- do_scan2 = do_scan, with two exceptions where it is forced 0:
  - reg_index2 == reg_index (port 1 wins; op_b still equals the same register's bits)
  - err condition below
- err condition: dst and src both in 8..15 and the latched indices differ. Only one port may address special registers.
  - err is latched at accept.
  - err is reported with done. It is not a reason to refuse the command.
- first = SCAN && bit_index == 0. last = SCAN && final step. Both are gated by !stall.
- stall high in SCAN:
  - do_scan, do_scan2, first, last are all 0
  - bit_index and indices hold
- stall in IDLE has no effect.
- Outside SCAN: do_scan = do_scan2 = 0, and reg_index / reg_index2 hold the last value.

## Timing
- Reset values:
  - state IDLE, cmd_ready 1
  - bit_index 0
  - reg_index 0, reg_index2 0
  - do_scan 0, do_scan2 0
  - first 0, last 0, done 0, err 0
- Reset mid-operation aborts immediately, and the partially scanned register is left as-is. Scan enables drop asynchronously.
- Accept at cycle T -> first scan step at T+1. Narrow ops scan T+1..T+4 and pulse done at T+5. Wide ops scan T+1..T+8 and pulse done at T+9.
- Each stall cycle delays done by one cycle.
- cmd_ready is high in the done cycle, so a back-to-back accept there starts scanning at the next cycle. Throughput is one narrow op per CYC+1 cycles.
- Command inputs are ignored except in the accept cycle.
- scan_in, scan_in2, op_a, op_b are combinational and carry zero added latency.

## Test plan
- Narrow op, dst=3, src=5, we=1, ALU adds:
  - do_scan high 4 cycles with bit_index 0,1,2,3
  - done at accept+5
  - r3 = r3+r5
  - r5 unchanged
  - first at step 0, last at step 3.
- Wide op, dst=2, src=6:
  - reg_index is 2 for steps 0..3, then 3 for steps 4..7
  - reg_index2 is 6 for steps 0..3, then 7 for steps 4..7
  - done at accept+9.
- src == dst = 4:
  - do_scan2 stays 0 throughout
  - op_b equals op_a every step
  - the result is written once.
- dst=8 (sp), src=10 (flags):
  - err=1 with done
  - do_scan2 always 0
  - no special register other than sp is modified.
- Stall:
  - stall held 2 cycles at step 1 -> bit_index holds at 1 and scans are gated for 2 cycles
  - done at accept+7
  - result identical to the unstalled case.
- Reset asserted at wide step 5, and a back-to-back pair of commands:
  - on reset, outputs go to reset values immediately and cmd_ready is 1
  - a second command accepted in the done cycle starts scanning the following cycle.

Source files
------------

// File: rtl/regfile_scan_sequencer.sv
// Bit-serial register-file operation sequencer: walks both register-file ports
// through one 8-bit or 16-bit (register-pair) operation, NSHIFT bits per step.
module regfile_scan_sequencer #(
  parameter  int LOG2_NR  = 4,
  parameter  int REG_BITS = 8,
  parameter  int NSHIFT   = 2,
  localparam int CYC      = REG_BITS / NSHIFT,
  localparam int BI_W     = $clog2(2 * CYC)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [LOG2_NR-1:0] cmd_dst,
  input  logic [LOG2_NR-1:0] cmd_src,
  input  logic               cmd_wide,
  input  logic               cmd_we,
  input  logic               stall,
  output logic [LOG2_NR-1:0] reg_index,
  output logic [LOG2_NR-1:0] reg_index2,
  output logic               do_scan,
  output logic               do_scan2,
  output logic [BI_W-1:0]    bit_index,
  input  logic [NSHIFT-1:0]  rf_scan_out,
  input  logic [NSHIFT-1:0]  rf_scan_out2,
  input  logic [NSHIFT-1:0]  alu_result,
  output logic [NSHIFT-1:0]  scan_in,
  output logic [NSHIFT-1:0]  scan_in2,
  output logic [NSHIFT-1:0]  op_a,
  output logic [NSHIFT-1:0]  op_b,
  output logic               first,
  output logic               last,
  output logic               done,
  output logic               err
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [BI_W-1:0] LAST_NARROW = BI_W'(CYC - 1);
  localparam logic [BI_W-1:0] LAST_WIDE   = BI_W'(2 * CYC - 1);

  state_t             state_reg;
  logic [BI_W-1:0]    bit_index_reg;
  logic [LOG2_NR-1:0] dst_reg;
  logic [LOG2_NR-1:0] src_reg;
  logic               wide_reg;
  logic               we_reg;
  logic               err_lat_reg;
  logic [LOG2_NR-1:0] reg_index_reg;
  logic [LOG2_NR-1:0] reg_index2_reg;
  logic               done_reg;
  logic               err_reg;

  logic               scanning;
  logic               final_step;
  logic [BI_W-1:0]    bit_index_next;
  logic               special_clash;

  // Wide ops step through the pair low register first; the top bit_index bit
  // selects the high half.
  function automatic logic [LOG2_NR-1:0] port_index(input logic [LOG2_NR-1:0] base,
                                                    input logic               wide,
                                                    input logic [BI_W-1:0]    bi);
    return wide ? {base[LOG2_NR-1:1], bi[BI_W-1]} : base;
  endfunction

  assign scanning       = (state_reg == SCAN) && !stall;
  assign final_step     = bit_index_reg == (wide_reg ? LAST_WIDE : LAST_NARROW);
  assign bit_index_next = bit_index_reg + BI_W'(1);
  // Both ports may not address distinct special registers in one operation.
  assign special_clash  = cmd_dst[LOG2_NR-1] && cmd_src[LOG2_NR-1] && (cmd_dst != cmd_src);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      bit_index_reg  <= '0;
      dst_reg        <= '0;
      src_reg        <= '0;
      wide_reg       <= 1'b0;
      we_reg         <= 1'b0;
      err_lat_reg    <= 1'b0;
      reg_index_reg  <= '0;
      reg_index2_reg <= '0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            state_reg      <= SCAN;
            dst_reg        <= cmd_dst;
            src_reg        <= cmd_src;
            wide_reg       <= cmd_wide;
            we_reg         <= cmd_we;
            err_lat_reg    <= special_clash;
            bit_index_reg  <= '0;
            reg_index_reg  <= port_index(cmd_dst, cmd_wide, '0);
            reg_index2_reg <= port_index(cmd_src, cmd_wide, '0);
          end
        end
        SCAN: begin
          if (!stall) begin
            if (final_step) begin
              // Indices keep pointing at the last register touched.
              state_reg     <= IDLE;
              bit_index_reg <= '0;
              done_reg      <= 1'b1;
              err_reg       <= err_lat_reg;
            end else begin
              bit_index_reg  <= bit_index_next;
              reg_index_reg  <= port_index(dst_reg, wide_reg, bit_index_next);
              reg_index2_reg <= port_index(src_reg, wide_reg, bit_index_next);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign cmd_ready  = (state_reg == IDLE);
  assign bit_index  = bit_index_reg;
  assign reg_index  = reg_index_reg;
  assign reg_index2 = reg_index2_reg;
  assign do_scan    = scanning;
  // Port 1 owns a shared register; port 2 is also silenced on a special clash.
  assign do_scan2   = scanning && (reg_index_reg != reg_index2_reg) && !err_lat_reg;
  assign first      = scanning && (bit_index_reg == '0);
  assign last       = scanning && final_step;
  assign done       = done_reg;
  assign err        = err_reg;

  assign op_a     = rf_scan_out;
  assign op_b     = rf_scan_out2;
  assign scan_in  = we_reg ? alu_result : rf_scan_out;
  assign scan_in2 = rf_scan_out2;

endmodule

// File: tb/tb_regfile_scan_sequencer.sv
// Scoreboard bench: a bit-serial register file and adder surround the sequencer;
// a plain-arithmetic register model predicts each operation's end state.
module tb_regfile_scan_sequencer;

  localparam int LOG2_NR = 4;
  localparam int REG_BITS = 8;
  localparam int NSHIFT = 2;
  localparam int CYC = REG_BITS / NSHIFT;
  localparam int BI_W = 3;

  logic clk = 1'b0;
  logic reset;
  logic cmd_valid;
  logic cmd_ready;
  logic [3:0] cmd_dst;
  logic [3:0] cmd_src;
  logic cmd_wide;
  logic cmd_we;
  logic stall;
  logic [3:0] reg_index;
  logic [3:0] reg_index2;
  logic do_scan;
  logic do_scan2;
  logic [2:0] bit_index;
  logic [1:0] rf_scan_out;
  logic [1:0] rf_scan_out2;
  logic [1:0] alu_result;
  logic [1:0] scan_in;
  logic [1:0] scan_in2;
  logic [1:0] op_a;
  logic [1:0] op_b;
  logic first;
  logic last;
  logic done;
  logic err;

  always #5 clk = ~clk;

  regfile_scan_sequencer #(.LOG2_NR(LOG2_NR), .REG_BITS(REG_BITS), .NSHIFT(NSHIFT)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dst(cmd_dst), .cmd_src(cmd_src), .cmd_wide(cmd_wide), .cmd_we(cmd_we),
    .stall(stall), .reg_index(reg_index), .reg_index2(reg_index2),
    .do_scan(do_scan), .do_scan2(do_scan2), .bit_index(bit_index),
    .rf_scan_out(rf_scan_out), .rf_scan_out2(rf_scan_out2), .alu_result(alu_result),
    .scan_in(scan_in), .scan_in2(scan_in2), .op_a(op_a), .op_b(op_b),
    .first(first), .last(last), .done(done), .err(err)
  );

  // Environment: register file with slice-addressed scan ports plus a serial adder.
  logic [7:0] rf [16];
  logic       rf_init;
  logic       carry_reg;
  logic [2:0] sum;

  assign rf_scan_out  = rf[reg_index][{bit_index[1:0], 1'b0} +: 2];
  assign rf_scan_out2 = rf[reg_index2][{bit_index[1:0], 1'b0} +: 2];
  assign sum          = {1'b0, op_a} + {1'b0, op_b} + {2'b00, (first ? 1'b0 : carry_reg)};
  assign alu_result   = sum[1:0];

  // Port 2 is written after port 1 so a wrongly enabled port 2 clobbers results.
  always @(posedge clk) begin
    if (rf_init) begin
      for (int i = 0; i < 16; i++) rf[i] <= 8'($urandom);
      carry_reg <= 1'b0;
    end else begin
      if (do_scan) begin
        rf[reg_index][{bit_index[1:0], 1'b0} +: 2] <= scan_in;
        carry_reg <= sum[2];
      end
      if (do_scan2) rf[reg_index2][{bit_index[1:0], 1'b0} +: 2] <= scan_in2;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [3:0]   dst;
    logic [3:0]   src;
    logic         wide;
    logic         we;
    logic         err;
    logic [127:0] snap;
  } op_t;

  op_t        sb_q[$];
  logic [7:0] model [16];

  function automatic logic [127:0] pack_rf();
    logic [127:0] p;
    for (int i = 0; i < 16; i++) p[8*i +: 8] = rf[i];
    return p;
  endfunction

  function automatic logic [127:0] pack_model();
    logic [127:0] p;
    for (int i = 0; i < 16; i++) p[8*i +: 8] = model[i];
    return p;
  endfunction

  // Stall driver: random mode or directed level.
  logic stall_rand;
  logic stall_force;
  initial begin
    stall = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      stall = stall_rand ? ($urandom_range(0, 3) == 0) : stall_force;
    end
  end

  // Monitor: follows each accepted command and pops its expectation at done.
  op_t        cur;
  logic       in_op = 1'b0;
  int         acc_cyc, step, stall_cnt, nsteps;
  logic [3:0] exp_i1, exp_i2;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        in_op = 1'b0;
        sb_q.delete();
      end else begin
        if (in_op) begin
          nsteps = cur.wide ? 2 * CYC : CYC;
          if (done) begin
            $display("op dst=%0d src=%0d wide=%0b we=%0b: done after %0d cycles, err=%0b",
                     cur.dst, cur.src, cur.wide, cur.we, cyc - acc_cyc, err);
            chk("latency", 128'(cyc - acc_cyc), 128'(nsteps + 1 + stall_cnt));
            chk("steps", 128'(step), 128'(nsteps));
            chk("err", 128'(err), 128'(cur.err));
            chk("regfile", pack_rf(), cur.snap);
            void'(sb_q.pop_front());
            in_op = 1'b0;
          end else if (stall) begin
            chk("stall_gate", 128'({do_scan, do_scan2, first, last}), 128'(0));
            stall_cnt++;
          end else begin
            exp_i1 = cur.wide ? {cur.dst[3:1], step >= CYC} : cur.dst;
            exp_i2 = cur.wide ? {cur.src[3:1], step >= CYC} : cur.src;
            chk("do_scan", 128'(do_scan), 128'(1));
            chk("bit_index", 128'(bit_index), 128'(step));
            chk("reg_index", 128'(reg_index), 128'(exp_i1));
            chk("reg_index2", 128'(reg_index2), 128'(exp_i2));
            chk("do_scan2", 128'(do_scan2), 128'((exp_i1 != exp_i2) && !cur.err));
            chk("first", 128'(first), 128'(step == 0));
            chk("last", 128'(last), 128'(step == nsteps - 1));
            chk("op_b", 128'(op_b), 128'(rf[exp_i2][2*(step % CYC) +: 2]));
            step++;
          end
          if (in_op && (cyc - acc_cyc > 60)) begin
            chk("done_timeout", 128'(cyc - acc_cyc), 128'(nsteps + 1 + stall_cnt));
            void'(sb_q.pop_front());
            in_op = 1'b0;
          end
        end else begin
          chk("idle_quiet", 128'({do_scan, do_scan2, done, err}), 128'(0));
        end
        if (cmd_valid && cmd_ready) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_accept", 128'(1), 128'(0));
          end else begin
            cur       = sb_q[0];
            in_op     = 1'b1;
            acc_cyc   = cyc;
            step      = 0;
            stall_cnt = 0;
          end
        end
      end
    end
  end

  // Predict the operation with whole-register arithmetic, then offer it.
  task automatic issue(input logic [3:0] d, input logic [3:0] s, input logic w,
                       input logic e, output int acc);
    op_t         o;
    logic [15:0] a, b, r;
    logic        got;
    o.dst  = d;
    o.src  = s;
    o.wide = w;
    o.we   = e;
    o.err  = d[3] && s[3] && (d != s);
    if (e) begin
      if (w) begin
        a = {model[{d[3:1], 1'b1}], model[{d[3:1], 1'b0}]};
        b = {model[{s[3:1], 1'b1}], model[{s[3:1], 1'b0}]};
        r = a + b;
        model[{d[3:1], 1'b0}] = r[7:0];
        model[{d[3:1], 1'b1}] = r[15:8];
      end else begin
        model[d] = model[d] + model[s];
      end
    end
    o.snap = pack_model();
    sb_q.push_back(o);
    cmd_valid = 1'b1;
    cmd_dst   = d;
    cmd_src   = s;
    cmd_wide  = w;
    cmd_we    = e;
    got       = 1'b0;
    acc       = -1;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      if (cmd_ready) begin
        got = 1'b1;
        acc = cyc;
      end
    end
    if (!got) chk("accept_timeout", 128'(0), 128'(1));
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_dst   = 4'($urandom);
    cmd_src   = 4'($urandom);
    cmd_wide  = 1'($urandom);
    cmd_we    = 1'($urandom);
  endtask

  task automatic check_reset_vals(input string name);
    chk(name, 128'({cmd_ready, do_scan, do_scan2, bit_index, reg_index, reg_index2,
                    first, last, done, err}), 128'(18'h20000));
  endtask

  int a1, a2;

  initial begin
    reset       = 1'b1;
    cmd_valid   = 1'b0;
    cmd_dst     = '0;
    cmd_src     = '0;
    cmd_wide    = 1'b0;
    cmd_we      = 1'b0;
    stall_rand  = 1'b0;
    stall_force = 1'b0;
    rf_init     = 1'b1;
    @(posedge clk);
    #1;
    rf_init = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = rf[i];
    check_reset_vals("reset_state");
    @(negedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;

    issue(4'd3, 4'd5, 1'b0, 1'b1, a1);
    issue(4'd2, 4'd6, 1'b1, 1'b1, a1);
    issue(4'd4, 4'd4, 1'b0, 1'b1, a1);
    issue(4'd8, 4'd10, 1'b0, 1'b1, a1);

    // Two stall cycles at step 1.
    issue(4'd3, 4'd5, 1'b0, 1'b1, a1);
    @(posedge clk);
    stall_force = 1'b1;
    @(posedge clk);
    @(posedge clk);
    stall_force = 1'b0;

    // Back-to-back: second command accepted in the first one's done cycle.
    issue(4'd1, 4'd7, 1'b0, 1'b1, a1);
    issue(4'd9, 4'd2, 1'b0, 1'b0, a2);
    chk("b2b_accept", 128'(a2), 128'(a1 + CYC + 1));

    // Asynchronous reset in wide step 5.
    issue(4'd2, 4'd6, 1'b1, 1'b1, a1);
    repeat (5) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_reset_vals("mid_op_reset");
    @(negedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) model[i] = rf[i];

    stall_rand = 1'b1;
    repeat (60) begin
      issue(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            1'($urandom), ($urandom_range(0, 3) != 0), a1);
    end
    stall_rand = 1'b0;
    for (int i = 0; i < 300 && sb_q.size() != 0; i++) @(posedge clk);
    if (sb_q.size() != 0) chk("drain", 128'(sb_q.size()), 128'(0));
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
